// File: rtl/multiplier_pkg.sv
// Shared widths, legal latency set and partial-product recombination for the 64x64 multiplier.
package multiplier_pkg;

  localparam int OPERAND_W = 64;
  localparam int PRODUCT_W = 128;
  localparam int PP_W      = 32;

  localparam int DELAY_MIN = 1;
  localparam int DELAY_MAX = 2;

  typedef logic [2*PP_W-1:0]    pp_t;
  typedef logic [PRODUCT_W-1:0] product_t;

  function automatic logic isLegalDelay(input int delay);
    return (delay == DELAY_MIN) || (delay == DELAY_MAX);
  endfunction

  // Cross terms both land at bit 32; the high-high term lands at bit 64.
  function automatic product_t sumPartials(input pp_t ll, input pp_t lh, input pp_t hl, input pp_t hh);
    return product_t'(ll)
         + (product_t'(lh) << PP_W)
         + (product_t'(hl) << PP_W)
         + (product_t'(hh) << (2*PP_W));
  endfunction

endpackage

// File: rtl/multiplier_mult32x32.sv
// Unsigned 32x32 -> 64 partial-product multiplier used four times by the top.
module mult32x32
  import multiplier_pkg::*;
(
  input  logic [PP_W-1:0]   i_a,
  input  logic [PP_W-1:0]   i_b,
  output logic [2*PP_W-1:0] o_p
);

  assign o_p = {{PP_W{1'b0}}, i_a} * {{PP_W{1'b0}}, i_b};

endmodule

// File: rtl/multiplier.sv
// Registered unsigned 64x64 -> 128 multiplier with 1- or 2-cycle latency.
// Optional out_valid strobe is enabled by defining MULTIPLIER_OUT_VALID_EN.
module multiplier
  import multiplier_pkg::*;
#(
  parameter int MULTIPLIER_DELAY = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [127:0]   in_A,
  input  logic [127:0]   in_B,
  input  logic           in_valid,
  output logic [127:0]   product
`ifdef MULTIPLIER_OUT_VALID_EN
  ,
  output logic           out_valid
`endif
);

  logic [PP_W-1:0] w_aLo, w_aHi, w_bLo, w_bHi;
  pp_t             w_pp [4];
  logic            w_loadProduct;
  product_t        w_sum;
  product_t        r_product;
  logic            w_unusedUpper;

  // Upper operand halves are architecturally ignored.
  assign w_unusedUpper = ^{in_A[127:OPERAND_W], in_B[127:OPERAND_W]};

  assign w_aLo = in_A[PP_W-1:0];
  assign w_aHi = in_A[OPERAND_W-1:PP_W];
  assign w_bLo = in_B[PP_W-1:0];
  assign w_bHi = in_B[OPERAND_W-1:PP_W];

  mult32x32 uMultLL (.i_a(w_aLo), .i_b(w_bLo), .o_p(w_pp[0]));
  mult32x32 uMultLH (.i_a(w_aLo), .i_b(w_bHi), .o_p(w_pp[1]));
  mult32x32 uMultHL (.i_a(w_aHi), .i_b(w_bLo), .o_p(w_pp[2]));
  mult32x32 uMultHH (.i_a(w_aHi), .i_b(w_bHi), .o_p(w_pp[3]));

  generate
    if (!isLegalDelay(MULTIPLIER_DELAY)) begin : gBadDelay
      $error("multiplier: MULTIPLIER_DELAY must be 1 or 2");
      assign w_loadProduct = 1'b0;
      assign w_sum         = '0;
    end else if (MULTIPLIER_DELAY == 1) begin : gDelay1
      assign w_loadProduct = in_valid;
      assign w_sum         = sumPartials(w_pp[0], w_pp[1], w_pp[2], w_pp[3]);
    end else begin : gDelay2
      pp_t  r_pp [4];
      logic r_stage1Valid;

      // Stage boundary sits after the partial products; summation happens in stage 2.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_stage1Valid <= 1'b0;
          for (int i = 0; i < 4; i++) r_pp[i] <= '0;
        end else begin
          r_stage1Valid <= in_valid;
          if (in_valid) begin
            for (int i = 0; i < 4; i++) r_pp[i] <= w_pp[i];
          end
        end
      end

      assign w_loadProduct = r_stage1Valid;
      assign w_sum         = sumPartials(r_pp[0], r_pp[1], r_pp[2], r_pp[3]);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_product <= '0;
    end else if (w_loadProduct) begin
      r_product <= w_sum;
    end
  end

  assign product = r_product;

`ifdef MULTIPLIER_OUT_VALID_EN
  logic r_outValid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_outValid <= 1'b0;
    end else begin
      r_outValid <= w_loadProduct;
    end
  end

  assign out_valid = r_outValid;
`endif

endmodule

// File: tb/tb_multiplier.sv
// Directed self-checking bench: one 1-cycle and one 2-cycle multiplier driven from shared inputs.
module tb_multiplier;

  logic         clk = 1'b0;
  logic         resetN;
  logic [127:0] inA, inB;
  logic         inValid;
  logic [127:0] product1, product2;
`ifdef MULTIPLIER_OUT_VALID_EN
  logic         outValid1, outValid2;
`endif

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  multiplier #(.MULTIPLIER_DELAY(1)) dut1 (
    .clk(clk), .reset_n(resetN), .in_A(inA), .in_B(inB),
    .in_valid(inValid), .product(product1)
`ifdef MULTIPLIER_OUT_VALID_EN
    , .out_valid(outValid1)
`endif
  );

  multiplier #(.MULTIPLIER_DELAY(2)) dut2 (
    .clk(clk), .reset_n(resetN), .in_A(inA), .in_B(inB),
    .in_valid(inValid), .product(product2)
`ifdef MULTIPLIER_OUT_VALID_EN
    , .out_valid(outValid2)
`endif
  );

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkValids(input string tag, input logic exp1, input logic exp2);
`ifdef MULTIPLIER_OUT_VALID_EN
    checkOutput({tag, " ov1"}, {127'b0, outValid1}, {127'b0, exp1});
    checkOutput({tag, " ov2"}, {127'b0, outValid2}, {127'b0, exp2});
`else
    if (exp1 || exp2 || tag.len() == 0) begin end
`endif
  endtask

  // Drives one valid beat; returns on the negedge right after the sampling edge.
  task automatic applyStimulus(input logic [127:0] a, input logic [127:0] b);
    @(negedge clk);
    inA     = a;
    inB     = b;
    inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
  endtask

  task automatic runCase(input string tag, input logic [127:0] a, input logic [127:0] b,
                         input logic [127:0] expected);
    applyStimulus(a, b);
    checkOutput({tag, " d1"}, product1, expected);
    checkValids({tag, " first"}, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput({tag, " d2"}, product2, expected);
    checkValids({tag, " second"}, 1'b0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetN  = 1'b0;
    inA     = '0;
    inB     = '0;
    inValid = 1'b0;
    #12;
    checkOutput("reset d1", product1, 128'd0);
    checkOutput("reset d2", product2, 128'd0);
    checkValids("reset", 1'b0, 1'b0);
    @(negedge clk);
    resetN = 1'b1;

    runCase("3x5", 128'd3, 128'd5, 128'd15);
    @(negedge clk);
    checkOutput("3x5 hold d1", product1, 128'd15);
    checkOutput("3x5 hold d2", product2, 128'd15);
    checkValids("3x5 hold", 1'b0, 1'b0);

    runCase("allones", {64'd0, 64'hFFFF_FFFF_FFFF_FFFF}, {64'd0, 64'hFFFF_FFFF_FFFF_FFFF},
            128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    runCase("crossLH", {64'd0, 64'h0000_0000_FFFF_FFFF}, {64'd0, 64'h0000_0001_0000_0000},
            128'h0000_0000_0000_0000_FFFF_FFFF_0000_0000);
    runCase("crossHL", {64'd0, 64'h0000_0001_0000_0000}, {64'd0, 64'h0000_0000_FFFF_FFFF},
            128'h0000_0000_0000_0000_FFFF_FFFF_0000_0000);
    runCase("hihi", {64'd0, 64'h0000_0001_0000_0000}, {64'd0, 64'h0000_0001_0000_0000},
            128'h0000_0000_0000_0001_0000_0000_0000_0000);
    runCase("allterms", {64'd0, 64'h0000_0001_0000_0001}, {64'd0, 64'h0000_0001_0000_0001},
            128'h0000_0000_0000_0001_0000_0002_0000_0001);
    runCase("upperIgnored", {64'hFFFF_FFFF_FFFF_FFFF, 64'd2}, {64'hA5A5_5A5A_1234_8765, 64'h8000_0000_0000_0000},
            128'h0000_0000_0000_0001_0000_0000_0000_0000);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      inA     = {$urandom, $urandom, $urandom, $urandom};
      inB     = {$urandom, $urandom, $urandom, $urandom};
      inValid = 1'b0;
      checkOutput($sformatf("idle%0d d1", i), product1, 128'h0000_0000_0000_0001_0000_0000_0000_0000);
      checkOutput($sformatf("idle%0d d2", i), product2, 128'h0000_0000_0000_0001_0000_0000_0000_0000);
    end

    @(negedge clk);
    inA     = 128'd2;
    inB     = 128'd3;
    inValid = 1'b1;
    @(negedge clk);
    checkOutput("b2b first d1", product1, 128'd6);
    inA = 128'd7;
    inB = 128'd11;
    @(negedge clk);
    inValid = 1'b0;
    checkOutput("b2b second d1", product1, 128'd77);
    checkOutput("b2b first d2", product2, 128'd6);
    checkValids("b2b mid", 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("b2b second d2", product2, 128'd77);
    checkOutput("b2b hold d1", product1, 128'd77);
    checkValids("b2b end", 1'b0, 1'b1);

    @(negedge clk);
    inA     = 128'd9;
    inB     = 128'd9;
    inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    resetN  = 1'b0;
    #1;
    checkOutput("midreset d1", product1, 128'd0);
    checkOutput("midreset d2", product2, 128'd0);
    checkValids("midreset", 1'b0, 1'b0);
    @(negedge clk);
    resetN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("nostale%0d d1", i), product1, 128'd0);
      checkOutput($sformatf("nostale%0d d2", i), product2, 128'd0);
    end

    @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    resetN  = 1'b1;
    inA     = 128'd4;
    inB     = 128'd5;
    inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    checkOutput("firstedge d1", product1, 128'd20);
    @(negedge clk);
    checkOutput("firstedge d2", product2, 128'd20);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
